// File: rtl/vga_timing_multi.sv
// Two-mode VGA timing generator: pixel/line counters with registered, mutually
// aligned sync, blanking and frame-start flags; mode switches only at frame wrap.
module vga_timing_multi #(
  parameter int       CNT_W       = 11,
  parameter int       M0_H_ACTIVE = 800,
  parameter int       M0_H_FP     = 40,
  parameter int       M0_H_SYNC   = 128,
  parameter int       M0_H_BP     = 88,
  parameter int       M0_V_ACTIVE = 600,
  parameter int       M0_V_FP     = 1,
  parameter int       M0_V_SYNC   = 4,
  parameter int       M0_V_BP     = 23,
  parameter int       M1_H_ACTIVE = 1024,
  parameter int       M1_H_FP     = 24,
  parameter int       M1_H_SYNC   = 136,
  parameter int       M1_H_BP     = 160,
  parameter int       M1_V_ACTIVE = 768,
  parameter int       M1_V_FP     = 3,
  parameter int       M1_V_SYNC   = 6,
  parameter int       M1_V_BP     = 29,
  parameter bit       HS_POL      = 1'b1,
  parameter bit       VS_POL      = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_en,
  input  logic             mode_sel,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             frame_start,
  output logic             mode_act
);

  localparam int M0_HT = M0_H_ACTIVE + M0_H_FP + M0_H_SYNC + M0_H_BP;
  localparam int M0_VT = M0_V_ACTIVE + M0_V_FP + M0_V_SYNC + M0_V_BP;
  localparam int M1_HT = M1_H_ACTIVE + M1_H_FP + M1_H_SYNC + M1_H_BP;
  localparam int M1_VT = M1_V_ACTIVE + M1_V_FP + M1_V_SYNC + M1_V_BP;

  if ((M0_HT - 1) >= (1 << CNT_W) || (M0_VT - 1) >= (1 << CNT_W) ||
      (M1_HT - 1) >= (1 << CNT_W) || (M1_VT - 1) >= (1 << CNT_W)) begin : g_cnt_w_check
    $fatal(1, "vga_timing_multi: CNT_W too narrow for the configured totals");
  end

  localparam logic [CNT_W-1:0] C0_HMAX = CNT_W'(M0_HT - 1);
  localparam logic [CNT_W-1:0] C0_VMAX = CNT_W'(M0_VT - 1);
  localparam logic [CNT_W-1:0] C0_HA   = CNT_W'(M0_H_ACTIVE);
  localparam logic [CNT_W-1:0] C0_HSS  = CNT_W'(M0_H_ACTIVE + M0_H_FP);
  localparam logic [CNT_W-1:0] C0_HSE  = CNT_W'(M0_H_ACTIVE + M0_H_FP + M0_H_SYNC);
  localparam logic [CNT_W-1:0] C0_VA   = CNT_W'(M0_V_ACTIVE);
  localparam logic [CNT_W-1:0] C0_VSS  = CNT_W'(M0_V_ACTIVE + M0_V_FP);
  localparam logic [CNT_W-1:0] C0_VSE  = CNT_W'(M0_V_ACTIVE + M0_V_FP + M0_V_SYNC);
  localparam logic [CNT_W-1:0] C1_HMAX = CNT_W'(M1_HT - 1);
  localparam logic [CNT_W-1:0] C1_VMAX = CNT_W'(M1_VT - 1);
  localparam logic [CNT_W-1:0] C1_HA   = CNT_W'(M1_H_ACTIVE);
  localparam logic [CNT_W-1:0] C1_HSS  = CNT_W'(M1_H_ACTIVE + M1_H_FP);
  localparam logic [CNT_W-1:0] C1_HSE  = CNT_W'(M1_H_ACTIVE + M1_H_FP + M1_H_SYNC);
  localparam logic [CNT_W-1:0] C1_VA   = CNT_W'(M1_V_ACTIVE);
  localparam logic [CNT_W-1:0] C1_VSS  = CNT_W'(M1_V_ACTIVE + M1_V_FP);
  localparam logic [CNT_W-1:0] C1_VSE  = CNT_W'(M1_V_ACTIVE + M1_V_FP + M1_V_SYNC);

  logic [CNT_W-1:0] r_h, r_v;
  logic             r_hs, r_vs, r_hb, r_vb, r_fs, r_mode;

  logic [CNT_W-1:0] w_hmax, w_vmax, w_h_nxt, w_v_nxt;
  logic [CNT_W-1:0] w_ha, w_hss, w_hse, w_va, w_vss, w_vse;
  logic             w_h_last, w_v_last, w_wrap, w_mode_nxt;

  always_comb begin
    w_hmax     = r_mode ? C1_HMAX : C0_HMAX;
    w_vmax     = r_mode ? C1_VMAX : C0_VMAX;
    w_h_last   = (r_h == w_hmax);
    w_v_last   = (r_v == w_vmax);
    w_wrap     = w_h_last && w_v_last;
    w_h_nxt    = w_h_last ? '0 : r_h + CNT_W'(1);
    w_v_nxt    = r_v;
    if (w_h_last) w_v_nxt = w_v_last ? '0 : r_v + CNT_W'(1);
    // Flags for the next position always come from the mode that position belongs to.
    w_mode_nxt = w_wrap ? mode_sel : r_mode;
    w_ha       = w_mode_nxt ? C1_HA  : C0_HA;
    w_hss      = w_mode_nxt ? C1_HSS : C0_HSS;
    w_hse      = w_mode_nxt ? C1_HSE : C0_HSE;
    w_va       = w_mode_nxt ? C1_VA  : C0_VA;
    w_vss      = w_mode_nxt ? C1_VSS : C0_VSS;
    w_vse      = w_mode_nxt ? C1_VSE : C0_VSE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h    <= '0;
      r_v    <= '0;
      r_hb   <= 1'b0;
      r_vb   <= 1'b0;
      r_hs   <= ~HS_POL;
      r_vs   <= ~VS_POL;
      r_fs   <= 1'b0;
      r_mode <= mode_sel;
    end else begin
      r_fs <= 1'b0;
      if (pix_en) begin
        r_h    <= w_h_nxt;
        r_v    <= w_v_nxt;
        r_mode <= w_mode_nxt;
        r_fs   <= w_wrap;
        r_hb   <= (w_h_nxt >= w_ha);
        r_vb   <= (w_v_nxt >= w_va);
        r_hs   <= ((w_h_nxt >= w_hss) && (w_h_nxt < w_hse)) ? HS_POL : ~HS_POL;
        r_vs   <= ((w_v_nxt >= w_vss) && (w_v_nxt < w_vse)) ? VS_POL : ~VS_POL;
      end
    end
  end

  assign hcount      = r_h;
  assign vcount      = r_v;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign hblnk       = r_hb;
  assign vblnk       = r_vb;
  assign frame_start = r_fs;
  assign mode_act    = r_mode;

endmodule

// File: tb/tb_vga_timing_multi.sv
// Random pix_en / mode_sel / reset stimulus against a frame-position model that
// tracks the linear pixel index within the frame and derives all outputs from it.
module tb_vga_timing_multi;

  localparam int CNT_W = 8;
  localparam int HA[2] = '{8, 10};
  localparam int HF[2] = '{2, 1};
  localparam int HS[2] = '{3, 2};
  localparam int HB[2] = '{2, 3};
  localparam int VA[2] = '{4, 5};
  localparam int VF[2] = '{1, 2};
  localparam int VS[2] = '{2, 1};
  localparam int VB[2] = '{1, 2};
  localparam bit HS_POL = 1'b1;
  localparam bit VS_POL = 1'b0;
  localparam int N_CYCLES = 20000;

  logic             clk, rst_n, pix_en, mode_sel;
  logic [CNT_W-1:0] hcount, vcount;
  logic             hsync, vsync, hblnk, vblnk, frame_start, mode_act;

  int n_checks = 0;
  int n_fail   = 0;

  vga_timing_multi #(
    .CNT_W(CNT_W),
    .M0_H_ACTIVE(HA[0]), .M0_H_FP(HF[0]), .M0_H_SYNC(HS[0]), .M0_H_BP(HB[0]),
    .M0_V_ACTIVE(VA[0]), .M0_V_FP(VF[0]), .M0_V_SYNC(VS[0]), .M0_V_BP(VB[0]),
    .M1_H_ACTIVE(HA[1]), .M1_H_FP(HF[1]), .M1_H_SYNC(HS[1]), .M1_H_BP(HB[1]),
    .M1_V_ACTIVE(VA[1]), .M1_V_FP(VF[1]), .M1_V_SYNC(VS[1]), .M1_V_BP(VB[1]),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .mode_sel(mode_sel),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .hblnk(hblnk), .vblnk(vblnk), .frame_start(frame_start), .mode_act(mode_act)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: linear pixel index within the current frame
  int m_p, m_mode, m_fs, m_in_rst, m_frames;

  function automatic int htot(input int m); return HA[m] + HF[m] + HS[m] + HB[m]; endfunction
  function automatic int vtot(input int m); return VA[m] + VF[m] + VS[m] + VB[m]; endfunction

  task automatic model_step(input logic r, input logic en, input logic sel);
    m_fs = 0;
    if (!r) begin
      m_p = 0; m_mode = int'(sel); m_in_rst = 1;
    end else if (en) begin
      m_in_rst = 0;
      m_p = m_p + 1;
      if (m_p == htot(m_mode) * vtot(m_mode)) begin
        m_p = 0; m_mode = int'(sel); m_fs = 1; m_frames++;
      end
    end
  endtask

  task automatic compare_all();
    int h, v;
    logic e_hb, e_vb, e_hs, e_vs;
    h = m_p % htot(m_mode);
    v = m_p / htot(m_mode);
    if (m_in_rst != 0) begin
      e_hb = 1'b0; e_vb = 1'b0; e_hs = ~HS_POL; e_vs = ~VS_POL;
    end else begin
      e_hb = (h >= HA[m_mode]);
      e_vb = (v >= VA[m_mode]);
      e_hs = (h >= HA[m_mode] + HF[m_mode] && h < HA[m_mode] + HF[m_mode] + HS[m_mode]) ? HS_POL : ~HS_POL;
      e_vs = (v >= VA[m_mode] + VF[m_mode] && v < VA[m_mode] + VF[m_mode] + VS[m_mode]) ? VS_POL : ~VS_POL;
    end
    check_eq("hcount", 32'(hcount), 32'(h));
    check_eq("vcount", 32'(vcount), 32'(v));
    check_eq("hblnk", 32'(hblnk), 32'(e_hb));
    check_eq("vblnk", 32'(vblnk), 32'(e_vb));
    check_eq("hsync", 32'(hsync), 32'(e_hs));
    check_eq("vsync", 32'(vsync), 32'(e_vs));
    check_eq("frame_start", 32'(frame_start), 32'(m_fs));
    check_eq("mode_act", 32'(mode_act), 32'(m_mode));
  endtask

  // driver: one clock of stimulus, model update, then sampling after the edge
  task automatic drive_cycle(input logic r, input logic en, input logic sel);
    @(negedge clk);
    rst_n = r; pix_en = en; mode_sel = sel;
    @(posedge clk);
    model_step(r, en, sel);
    #1;
    compare_all();
  endtask

  initial begin
    int rst_left, en_pct;
    logic sel;
    rst_n = 1'b0; pix_en = 1'b1; mode_sel = 1'b0;
    m_p = 0; m_mode = 0; m_fs = 0; m_in_rst = 1; m_frames = 0;
    sel = 1'b0;
    // reset with pix_en high must be ignored
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) drive_cycle(1'b1, 1'b0, 1'b1);
    // long stretch of full-rate pixels in mode 1, then mode 0 with toggling enable
    for (int i = 0; i < 400; i++) drive_cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 600; i++) drive_cycle(1'b1, 1'(i % 2), 1'b0);
    rst_left = 0;
    en_pct = 75;
    for (int i = 0; i < N_CYCLES; i++) begin
      if ($urandom_range(0, 29) == 0) sel = ~sel;
      if (rst_left == 0 && $urandom_range(0, 699) == 0) rst_left = $urandom_range(1, 3);
      if ($urandom_range(0, 1999) == 0) en_pct = $urandom_range(30, 100);
      drive_cycle(rst_left == 0, $urandom_range(1, 100) <= en_pct, sel);
      if (rst_left > 0) rst_left--;
    end
    // enough frame wraps must have been exercised for the run to be meaningful
    n_checks++;
    if (m_frames < 20) begin
      n_fail++;
      $display("FAIL frame_count got=%0d exp>=20", m_frames);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_multi.md
VGA_TIMING_MULTI -- requirements
Module: vga_timing_multi

Interface
REQ-001 Parameter CNT_W, default 11: width of hcount/vcount.
REQ-002 Parameters M0_H_ACTIVE/M0_H_FP/M0_H_SYNC/M0_H_BP, defaults 800/40/128/88: mode 0 horizontal timing in pixels.
REQ-003 Parameters M0_V_ACTIVE/M0_V_FP/M0_V_SYNC/M0_V_BP, defaults 600/1/4/23: mode 0 vertical timing in lines.
REQ-004 Parameters M1_H_ACTIVE/M1_H_FP/M1_H_SYNC/M1_H_BP, defaults 1024/24/136/160: mode 1 horizontal timing.
REQ-005 Parameters M1_V_ACTIVE/M1_V_FP/M1_V_SYNC/M1_V_BP, defaults 768/3/6/29: mode 1 vertical timing.
REQ-006 Parameters HS_POL/VS_POL, default 1'b1: sync level during sync pulse (1 = active-high).
REQ-007 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-008 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-009 Port pix_en, input, 1: pixel-rate clock enable; counters advance only when high.
REQ-010 Port mode_sel, input, 1: requested mode (0 or 1).
REQ-011 Port hcount, output, CNT_W: current pixel column.
REQ-012 Port vcount, output, CNT_W: current line.
REQ-013 Ports hsync/vsync, output, 1: sync pulses, polarity per HS_POL/VS_POL.
REQ-014 Ports hblnk/vblnk, output, 1: blanking flags, active-high.
REQ-015 Port frame_start, output, 1: one-cycle pulse at the first pixel of each frame.
REQ-016 Port mode_act, output, 1: mode currently being generated.

Function
REQ-017 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise, per active mode; mode 0 defaults 1056x628, mode 1 defaults 1344x806.
REQ-018 On a cycle with pix_en=1: hcount increments; at hcount=H_TOTAL-1 it wraps to 0 and vcount increments; at vcount=V_TOTAL-1 with the hcount wrap, vcount wraps to 0.
REQ-019 On a cycle with pix_en=0 every register holds, except frame_start, which is cleared.
REQ-020 All outputs are registered and mutually aligned: flags describe the hcount/vcount values presented in the same cycle.
REQ-021 hblnk=1 iff hcount >= H_ACTIVE; vblnk=1 iff vcount >= V_ACTIVE.
REQ-022 hsync active iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC; vsync active iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC; otherwise at inactive level.
REQ-023 mode_sel is sampled and copied to mode_act only on the pix_en cycle where both counters wrap to 0 (frame boundary); the first pixel of the new frame already uses the new mode's timing.
REQ-024 mode_sel changes mid-frame have no effect until the next frame boundary; only the value present at the boundary is used.
REQ-025 frame_start=1 for exactly one clk cycle, the cycle in which hcount=0 and vcount=0 are first presented.
REQ-026 Counter comparisons use CNT_W-bit unsigned arithmetic; H_TOTAL-1 and V_TOTAL-1 of both modes must fit in CNT_W (elaboration-time check; failure is a fatal error).
REQ-027 Simultaneous wrap and mode change: wrap values and new-mode flags are derived from the next mode, never a mix of both modes.

Reset
REQ-028 While rst_n=0 at a rising clk edge: hcount=0, vcount=0, hblnk=0, vblnk=0, hsync/vsync inactive, frame_start=0, mode_act=mode_sel.
REQ-029 Reset mid-frame discards position; the first pix_en cycle after release increments hcount to 1 (position 0,0 counts as already presented; no frame_start for it).
REQ-030 pix_en during reset is ignored.

Verification
REQ-031 Mode 1, pix_en=1 constantly, one frame -> hcount period 1344, hsync active at hcount 1048..1183, vsync active at vcount 771..776, frame_start period 1344*806 cycles.
REQ-032 Mode 0, pix_en toggling 1/0 -> hblnk rises at hcount 800, hsync active at 840..967, vsync at lines 601..604, counters frozen on every pix_en=0 cycle.
REQ-033 mode_sel 0->1 at vcount 300 -> mode_act stays 0 until the frame wrap; next frame runs 1344x806; frame_start coincides with mode_act change.
REQ-034 HS_POL=0, VS_POL=0 -> hsync/vsync low only inside the sync windows of REQ-031.
REQ-035 rst_n=0 for 2 cycles at hcount 500, vcount 400 -> all outputs at REQ-028 values; resumes from 1,0 after release; next frame_start after one full frame.
REQ-036 Elaboration with CNT_W=10 and mode 1 defaults -> fatal elaboration error.
